// File: rtl/shared_reg8_arbiter.sv
// Shared WIDTH-bit register with round-robin write arbitration, grant/ack handshake and priority clear.
// Optional SHREG_OWNER_EN adds Owner/Owner_vld outputs tracking the last writer.
module shared_reg8_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   localparam int PTR_W  = $clog2(NUM_REQ)
) (
   input  logic                       CLK,
   input  logic                       Asynch_clr_n,
   input  logic [NUM_REQ-1:0]         Req,
   input  logic [NUM_REQ*WIDTH-1:0]   Din,
   input  logic                       Clr_req,
   output logic [NUM_REQ-1:0]         Grant,
   output logic [NUM_REQ-1:0]         Ack,
   output logic                       Clr_ack,
   output logic                       Busy,
`ifdef SHREG_OWNER_EN
   output logic [PTR_W-1:0]           Owner,
   output logic                       Owner_vld,
`endif
   output logic [WIDTH-1:0]           Q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2,
      CLR   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 clr_ack_q, clr_ack_d;
   logic [WIDTH-1:0]     q_q, q_d;
`ifdef SHREG_OWNER_EN
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic                 owner_vld_q, owner_vld_d;
`endif

   // First set request bit strictly after the last winner, wrapping around.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [PTR_W-1:0]   ptr);
      logic [PTR_W-1:0] pick;
      logic [PTR_W-1:0] idx;
      logic             found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      logic [PTR_W-1:0] win;
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      ack_d     = '0;
      clr_ack_d = 1'b0;
      q_d       = q_q;
      win       = rr_pick(Req, ptr_q);
`ifdef SHREG_OWNER_EN
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (Clr_req) begin
               state_d   = CLR;
               q_d       = '0;
               clr_ack_d = 1'b1;
`ifdef SHREG_OWNER_EN
               owner_vld_d = 1'b0;
`endif
            end else if (|Req) begin
               state_d      = GRANT;
               ptr_d        = win;
               grant_d      = '0;
               grant_d[win] = 1'b1;
            end
         end
         GRANT: begin
            // Din is only looked at here; the requester may already have dropped Req.
            state_d = ACK;
            q_d     = Din[int'(ptr_q)*WIDTH +: WIDTH];
            ack_d   = grant_q;
`ifdef SHREG_OWNER_EN
            owner_d     = ptr_q;
            owner_vld_d = 1'b1;
`endif
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
         end
         CLR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Asynch_clr_n) begin
      if (!Asynch_clr_n) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_W'(NUM_REQ-1);
         grant_q   <= '0;
         ack_q     <= '0;
         clr_ack_q <= 1'b0;
         q_q       <= '0;
`ifdef SHREG_OWNER_EN
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         clr_ack_q <= clr_ack_d;
         q_q       <= q_d;
`ifdef SHREG_OWNER_EN
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
`endif
      end
   end

   assign Grant   = grant_q;
   assign Ack     = ack_q;
   assign Clr_ack = clr_ack_q;
   assign Busy    = (state_q != IDLE);
   assign Q       = q_q;
`ifdef SHREG_OWNER_EN
   assign Owner     = owner_q;
   assign Owner_vld = owner_vld_q;
`endif

endmodule

// File: tb/tb_shared_reg8_arbiter.sv
// Scoreboard bench for shared_reg8_arbiter: directed stimulus pushes expected Ack/Clr_ack events,
// a negedge monitor pops and compares them. Define SHREG_OWNER_EN to also cover Owner outputs.
module tb_shared_reg8_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;

   logic                     CLK;
   logic                     Asynch_clr_n;
   logic [NUM_REQ-1:0]       Req;
   logic [NUM_REQ*WIDTH-1:0] Din;
   logic                     Clr_req;
   logic [NUM_REQ-1:0]       Grant;
   logic [NUM_REQ-1:0]       Ack;
   logic                     Clr_ack;
   logic                     Busy;
   logic [WIDTH-1:0]         Q;
`ifdef SHREG_OWNER_EN
   logic [1:0]               Owner;
   logic                     Owner_vld;
`endif

   shared_reg8_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .CLK          (CLK),
      .Asynch_clr_n (Asynch_clr_n),
      .Req          (Req),
      .Din          (Din),
      .Clr_req      (Clr_req),
      .Grant        (Grant),
      .Ack          (Ack),
      .Clr_ack      (Clr_ack),
      .Busy         (Busy),
`ifdef SHREG_OWNER_EN
      .Owner        (Owner),
      .Owner_vld    (Owner_vld),
`endif
      .Q            (Q)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic               clr;
      logic [NUM_REQ-1:0] ack;
      logic [WIDTH-1:0]   q;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_wr(input logic [NUM_REQ-1:0] a, input logic [WIDTH-1:0] d);
      exp_t e;
      e.clr = 1'b0; e.ack = a; e.q = d;
      exp_q.push_back(e);
   endtask

   task automatic push_clr();
      exp_t e;
      e.clr = 1'b1; e.ack = '0; e.q = '0;
      exp_q.push_back(e);
   endtask

   // Waits for Ack[idx] (or Clr_ack when idx < 0), sampling 1 time unit after each rising edge.
   task automatic wait_evt(input int idx, input int budget, input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(posedge CLK); #1;
         if (idx < 0) seen = Clr_ack;
         else         seen = Ack[idx];
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s: event not seen within %0d cycles, expected it", name, budget);
      end
   endtask

   // Monitor: every Ack/Clr_ack pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (Asynch_clr_n && (|Ack || Clr_ack)) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_evt: got ack=%b clr_ack=%b q=%0d, expected none", Ack, Clr_ack, Q);
            end else begin
               e = exp_q.pop_front();
               check("sb_clr_ack", 32'(Clr_ack), 32'(e.clr));
               check("sb_ack", 32'(Ack), 32'(e.ack));
               check("sb_q", 32'(Q), 32'(e.q));
               if (!e.clr) check("sb_grant_held", 32'(Grant), 32'(e.ack));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      Asynch_clr_n = 1'b0;
      Req          = '0;
      Din          = '0;
      Clr_req      = 1'b0;

      // 1: reset, then idle with no requests
      #12;
      check("rst_q", 32'(Q), 0);
      check("rst_busy", 32'(Busy), 0);
      check("rst_grant", 32'(Grant), 0);
      @(posedge CLK); #1;
      Asynch_clr_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         check("idle_q", 32'(Q), 0);
         check("idle_busy", 32'(Busy), 0);
         check("idle_grant", 32'(Grant), 0);
      end

      // 2: single write from requester 0, Req dropped during GRANT
      Din[7:0] = 8'd26;
      Req      = 4'b0001;
      push_wr(4'b0001, 8'd26);
      @(posedge CLK); #1;
      check("t2_grant_e1", 32'(Grant), 32'b0001);
      check("t2_busy_e1", 32'(Busy), 1);
      Req = '0;
      @(posedge CLK); #1;
      check("t2_ack_e2", 32'(Ack), 32'b0001);
      check("t2_q_e2", 32'(Q), 26);
`ifdef SHREG_OWNER_EN
      check("t2_owner", 32'(Owner), 0);
      check("t2_owner_vld", 32'(Owner_vld), 1);
`endif
      @(posedge CLK); #1;
      check("t2_busy_e3", 32'(Busy), 0);
      check("t2_grant_e3", 32'(Grant), 0);
      check("t2_ack_e3", 32'(Ack), 0);

      // 3: all four requesting, round robin from a fresh pointer
      Asynch_clr_n = 1'b0;
      #2;
      Asynch_clr_n = 1'b1;
      @(posedge CLK); #1;
      Din = {8'd255, 8'd129, 8'd127, 8'd128};
      Req = 4'b1111;
      push_wr(4'b0001, 8'd128);
      push_wr(4'b0010, 8'd127);
      push_wr(4'b0100, 8'd129);
      push_wr(4'b1000, 8'd255);
      push_wr(4'b0001, 8'd128);
      repeat (13) @(posedge CLK);
      #1;
      Req = '0;
      repeat (4) @(posedge CLK);
      #1;
      check("t3_sb_drained", 32'(exp_q.size()), 0);
      check("t3_busy", 32'(Busy), 0);

      // 4: preload 127 via requester 1, then clear and write at the same edge
      Din[15:8] = 8'd127;
      Req       = 4'b0010;
      push_wr(4'b0010, 8'd127);
      wait_evt(1, 8, "t4_pre_ack");
      Req = '0;
      @(posedge CLK); #1;
      check("t4_pre_q", 32'(Q), 127);
      Din[15:8] = 8'd77;
      Req       = 4'b0010;
      Clr_req   = 1'b1;
      push_clr();
      push_wr(4'b0010, 8'd77);
      wait_evt(-1, 4, "t4_clr_ack");
      check("t4_q_cleared", 32'(Q), 0);
`ifdef SHREG_OWNER_EN
      check("t4_owner_vld", 32'(Owner_vld), 0);
`endif
      Clr_req = 1'b0;
      wait_evt(1, 8, "t4_wr_ack");
      Req = '0;
      @(posedge CLK); #1;

      // 5: clear requested while requester 2 holds the grant
      Din[23:16] = 8'd129;
      Req        = 4'b0100;
      push_wr(4'b0100, 8'd129);
      push_clr();
      @(posedge CLK); #1;
      check("t5_grant", 32'(Grant), 32'b0100);
      Clr_req = 1'b1;
      wait_evt(2, 4, "t5_wr_ack");
      Req = '0;
      wait_evt(-1, 6, "t5_clr_ack");
      Clr_req = 1'b0;
      check("t5_q_cleared", 32'(Q), 0);
      @(posedge CLK); #1;

      // 6: reset in the middle of a GRANT with Q=255
      Din[31:24] = 8'd255;
      Req        = 4'b1000;
      push_wr(4'b1000, 8'd255);
      wait_evt(3, 8, "t6_pre_ack");
      Req = '0;
      @(posedge CLK); #1;
      check("t6_pre_q", 32'(Q), 255);
      Din[7:0] = 8'd11;
      Req      = 4'b0001;
      @(posedge CLK); #1;
      check("t6_grant_before_rst", 32'(Grant), 32'b0001);
      Asynch_clr_n = 1'b0;
      #1;
      check("t6_q_rst", 32'(Q), 0);
      check("t6_grant_rst", 32'(Grant), 0);
      check("t6_busy_rst", 32'(Busy), 0);
`ifdef SHREG_OWNER_EN
      check("t6_owner_vld_rst", 32'(Owner_vld), 0);
`endif
      @(posedge CLK); #1;
      Req = '0;
      Asynch_clr_n = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      check("t6_q_after", 32'(Q), 0);
      check("t6_ack_after", 32'(Ack), 0);
      check("final_sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
